mips_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the next-generation MIPS core. Replaces the single-cycle multcont path: the core issues an op with a start pulse, stalls on busy, and reads HI/LO after done. Supports signed/unsigned MULT/DIV, MTHI/MTLO writes and an abort input for exception flushes.

---
 rtl/mips_muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational MULT/MULTU path.
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [OPW-1:0] OP_MULT  = OPW'(0);
    localparam logic [OPW-1:0] OP_MULTU = OPW'(1);
    localparam logic [OPW-1:0] OP_DIV   = OPW'(2);
    localparam logic [OPW-1:0] OP_DIVU  = OPW'(3);
    localparam logic [OPW-1:0] OP_MTHI  = OPW'(4);
    localparam logic [OPW-1:0] OP_MTLO  = OPW'(5);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_COMMIT} state_t;

    state_t           state;
    logic [W2-1:0]    acc;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
    logic [CW-1:0]    count;
    logic             neg_res;
    logic             neg_rem;
    logic             is_div;
    logic             dz;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic [WIDTH+1:0] div_diff;
    logic [W2-1:0]    div_next;
    logic [WIDTH-1:0] quo_raw;
    logic [WIDTH-1:0] rem_raw;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        signed_op = 1'b0;
        if (op == OP_MULT || op == OP_DIV)
            signed_op = 1'b1;
        a_neg = signed_op & srca[WIDTH-1];
        b_neg = signed_op & srcb[WIDTH-1];
        a_abs = a_neg ? (~srca + 1'b1) : srca;
        b_abs = b_neg ? (~srcb + 1'b1) : srcb;
    end

    always_comb begin
        mul_sum  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, opnd};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[W2-1:1]};

        // Trial subtract of the divisor from the shifted-in partial remainder.
        div_diff = {1'b0, acc[W2-1:WIDTH], acc[WIDTH-1]} - {2'b00, opnd};
        div_next = div_diff[WIDTH+1] ? {acc[W2-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        quo_raw  = acc[WIDTH-1:0];
        rem_raw  = acc[W2-1:WIDTH];
        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        quo_fix  = neg_res ? (~quo_raw + 1'b1) : quo_raw;
        rem_fix  = neg_rem ? (~rem_raw + 1'b1) : rem_raw;
        if (dz)
            quo_fix = '1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            acc     <= '0;
            opnd    <= '0;
            count   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            is_div  <= 1'b0;
            dz      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done    <= 1'b0;
            divzero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                                acc   <= W2'(a_abs) * W2'(b_abs);
                                state <= S_COMMIT;
`else
                                acc   <= {{WIDTH{1'b0}}, b_abs};
                                state <= S_MUL;
`endif
                                opnd    <= a_abs;
                                neg_res <= a_neg ^ b_neg;
                                neg_rem <= 1'b0;
                                is_div  <= 1'b0;
                                dz      <= 1'b0;
                                count   <= '0;
                                busy    <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc     <= {{WIDTH{1'b0}}, a_abs};
                                opnd    <= b_abs;
                                neg_res <= a_neg ^ b_neg;
                                neg_rem <= a_neg;
                                is_div  <= 1'b1;
                                dz      <= (srcb == '0);
                                count   <= '0;
                                busy    <= 1'b1;
                                state   <= S_DIV;
                            end
                            OP_MTHI: hi <= srca;
                            OP_MTLO: lo <= srca;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        acc   <= mul_next;
                        count <= count + 1'b1;
                        if (count == LAST)
                            state <= S_COMMIT;
                    end
                end
                S_DIV: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        acc   <= div_next;
                        count <= count + 1'b1;
                        if (count == LAST)
                            state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (!cancel) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[W2-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        done    <= 1'b1;
                        divzero <= is_div & dz;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: directed vectors, queue of expected commits, negedge monitor.
module tb_mips_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 2;   // negedge before accept edge -> negedge showing done

    localparam logic [2:0] MULT  = 3'd0;
    localparam logic [2:0] MULTU = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] DIVU  = 3'd3;
    localparam logic [2:0] MTHI  = 3'd4;
    localparam logic [2:0] MTLO  = 3'd5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        op = 3'd0;
    logic [WIDTH-1:0]  srca = '0;
    logic [WIDTH-1:0]  srcb = '0;
    logic              cancel = 1'b0;
    logic              busy;
    logic              done;
    logic              divzero;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    mips_muldiv_unit #(.WIDTH(WIDTH), .OPW(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srca    (srca),
        .srcb    (srcb),
        .cancel  (cancel),
        .busy    (busy),
        .done    (done),
        .divzero (divzero),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected commit for an op issued at the current negedge.
    task automatic push(input string name, input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        exp_t e;
        e.name = name;
        e.hi   = ehi;
        e.lo   = elo;
        e.dz   = edz;
        e.at   = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++)
            @(negedge clk);
        check("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {31'b0, done}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_lo"}, lo, e.lo);
                    check({e.name, "_divzero"}, {31'b0, divzero}, {31'b0, e.dz});
                    check({e.name, "_cycle"}, cyc, e.at);
                    check({e.name, "_busy"}, {31'b0, busy}, 32'h0);
                end
            end else if (divzero) begin
                check("divzero_without_done", {31'b0, divzero}, 32'h0);
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Signed and unsigned multiply
        push("mult_m2x3", 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        issue(MULT, 32'hFFFFFFFE, 32'h3);
        check("mult_busy", {31'b0, busy}, 32'h1);
        drain();
        push("multu_fffffffex3", 32'h00000002, 32'hFFFFFFFA, 1'b0);
        issue(MULTU, 32'hFFFFFFFE, 32'h3);
        drain();

        // Signed and unsigned divide
        push("div_m7by2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        issue(DIV, 32'hFFFFFFF9, 32'h2);
        drain();
        push("divu_100by7", 32'h2, 32'hE, 1'b0);
        issue(DIVU, 32'd100, 32'd7);
        drain();

        // Divide by zero and signed overflow
        push("divu_by0", 32'h00001234, 32'hFFFFFFFF, 1'b1);
        issue(DIVU, 32'h1234, 32'h0);
        drain();
        push("div_ovf", 32'h0, 32'h80000000, 1'b0);
        issue(DIV, 32'h80000000, 32'hFFFFFFFF);
        drain();

        // MTHI/MTLO back to back, never busy
        start = 1'b1; op = MTHI; srca = 32'hAAAA; srcb = '0;
        @(negedge clk);
        check("mthi_busy", {31'b0, busy}, 32'h0);
        op = MTLO; srca = 32'h5555;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_busy", {31'b0, busy}, 32'h0);
        check("mt_hi", hi, 32'hAAAA);
        check("mt_lo", lo, 32'h5555);

        // Cancel in IDLE has no effect; cancel with start suppresses the start
        cancel = 1'b1;
        issue(MTHI, 32'h1, 32'h0);
        check("cancel_mthi_hi", hi, 32'hAAAA);
        issue(MULT, 32'h2, 32'h2);
        check("cancel_mult_busy", {31'b0, busy}, 32'h0);
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_idle_lo", lo, 32'h5555);

        // Start while busy is ignored
        push("mult_5x5", 32'h0, 32'd25, 1'b0);
        issue(MULT, 32'd5, 32'd5);
        repeat (3) @(negedge clk);
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("ignored_busy", {31'b0, busy}, 32'h1);
        drain();

        // Cancel at cycle 5 of a MULT: no done, HI/LO keep 0/25
        issue(MULT, 32'd9, 32'd9);
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {31'b0, busy}, 32'h0);
        repeat (40) @(negedge clk);
        check("cancel_hi", hi, 32'h0);
        check("cancel_lo", lo, 32'd25);
        push("multu_6x7", 32'h0, 32'd42, 1'b0);
        issue(MULTU, 32'd6, 32'd7);
        drain();

        // Back-to-back: next op issued in the done cycle
        push("divu_b2b", 32'd4, 32'd11, 1'b0);
        issue(DIVU, 32'd59, 32'd5);
        for (int i = 0; i < 100 && !done; i++)
            @(negedge clk);
        check("b2b_done_seen", {31'b0, done}, 32'h1);
        push("mult_7xm3", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        issue(MULT, 32'd7, 32'hFFFFFFFD);
        drain();

        // Async reset mid-DIV at iteration 10
        issue(DIV, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("postrst_busy", {31'b0, busy}, 32'h0);
        check("postrst_lo", lo, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
